seq_adder_n: RTL and testbench
==============================

// Module: seq_adder_n
// PURPOSE
//   Multi-cycle N-bit adder: adds x + y + c_in one K-bit chunk per clock, LSB chunk first.
//   Carry ripples between chunks through a carry register.
//   Valid/ready handshake on input and output; operands and result are registered.
//   Replaces wide combinational ripple chains on datapaths where one cycle is too short.
// PARAMETERS
//   N  16  operand/result width; N % K == 0 is mandatory, elaboration error otherwise
//   K  4   chunk width added per cycle (1..N); latency = N/K cycles
// PORTS
//   clock      in   1  single clock, all state updates on rising edge
//   reset      in   1  synchronous, active-high
//   in_valid   in   1  x, y, c_in are valid
//   in_ready   out  1  block can accept an operation
//   x          in   N  operand A (unsigned, or two's complement when SEQ_ADDER_OVF_EN)
//   y          in   N  operand B
//   c_in       in   1  initial carry
//   out_valid  out  1  s, c_out are valid
//   out_ready  in   1  consumer takes the result
//   s          out  N  (x + y + c_in) mod 2^N
//   c_out      out  1  carry out of bit N-1
//   ovf        out  1  signed overflow; only present with SEQ_ADDER_OVF_EN
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; s=0; c_out=0; ovf=0; chunk index=0.
//   FSM states IDLE, RUN, DONE. Moore outputs: in_ready=(state==IDLE), out_valid=(state==DONE).
//   IDLE: on edge with in_valid=1 -> latch x, y; carry reg <= c_in; idx <= 0; go to RUN.
//     in_valid=0 -> stay in IDLE.
//   RUN: each edge adds x[idx*K +: K] + y[idx*K +: K] + carry.
//     The K-bit sum goes to s[idx*K +: K]; the chunk carry goes to the carry reg; idx++.
//     On the edge processing idx == N/K-1: c_out <= chunk carry; go to DONE.
//   Latency: out_valid rises exactly N/K edges after the accepting edge.
//     K == N gives 1 cycle; K == 1 gives N cycles (bit-serial).
//   DONE: s, c_out and ovf are held stable. out_ready=1 -> go to IDLE.
//     The result is dropped on that same edge; registers keep their last value.
//     out_ready=0 -> stay in DONE indefinitely; no data lost.
//   in_valid while in RUN or DONE: ignored (in_ready=0). Input is not buffered; the producer must hold it.
//   No overlap: a new operation is accepted at earliest on the edge after the DONE->IDLE edge.
//     Sustained throughput: one result per N/K+2 cycles.
//   x and y may change after acceptance without affecting the result (operands are registered).
//   Bits of s above the current chunk hold stale values during RUN; consumers read s only when out_valid=1.
//   reset during RUN or DONE: aborts immediately; the in-flight result is lost; all outputs take reset values.
//     reset has priority over every handshake.
//   Wrap-around: the sum is modulo 2^N; the overflowing bit appears only on c_out.
// CONFIGURATION
//   SEQ_ADDER_OVF_EN defined: port ovf exists.
//     On the final RUN edge: ovf <= carry into bit N-1 XOR carry out of bit N-1.
//     Computed from the MSB operand bits, not the chunk boundary. ovf is held in DONE and cleared by reset.
//   SEQ_ADDER_OVF_EN undefined: no ovf port, no ovf logic; all other behaviour is identical.
// STRUCTURE
//   seq_adder_defs.vh (shared include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//     Also the clog2-based width for idx, reused by later multi-cycle arithmetic blocks.
//   Sub-module full_adder_k #(K): combinational K-bit ripple adder (x, y, c_in -> s, c_out).
//     Built as a generate loop of full_adder cells.
//     Exposes the carry into the MSB cell as c_msb, which feeds ovf.
//   seq_adder_n holds the FSM, the operand/result/carry registers and the chunk mux/demux.
// TESTING  (N=16, K=4 unless stated)
//   Basic: x=16'h1234, y=16'h4321, c_in=0 -> s=16'h5555, c_out=0; out_valid exactly 4 edges after accept.
//   Full carry chain: x=16'hFFFF, y=16'h0000, c_in=1 -> s=16'h0000, c_out=1, across all chunk boundaries.
//   Backpressure and busy input:
//     out_ready=0 for 10 cycles in DONE -> s, c_out stable and in_ready=0.
//     in_valid pulsed during RUN -> ignored; next accept only after DONE->IDLE.
//   Reset mid-op: assert reset on the 2nd RUN edge -> next cycle IDLE, in_ready=1, out_valid=0, s=0, c_out=0.
//   Parameter sweep: K in {1,2,4,8,16}, 1000 random (x, y, c_in) each -> {c_out,s} == x+y+c_in, latency == N/K.
//   SEQ_ADDER_OVF_EN:
//     x=16'h7FFF, y=16'h0001 -> s=16'h8000, ovf=1, c_out=0.
//     x=16'hFFFF, y=16'h0001 -> ovf=0, c_out=1.

Source files
------------

// File: rtl/seq_adder_n_pkg.sv
// seq_adder_n_pkg: FSM state encodings and index-width helper shared by multi-cycle arithmetic blocks.
package seq_adder_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-chunk adder still needs a 1-bit index register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_adder_n_full_adder_k.sv
// full_adder_k: combinational K-bit ripple adder built from full-adder cells.
// With SEQ_ADDER_OVF_EN, also exposes the carry into the MSB cell (c_msb).
module full_adder_k #(
    parameter int K = 4
) (
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    input  logic         c_in,
    output logic [K-1:0] s,
    output logic         c_out
`ifdef SEQ_ADDER_OVF_EN
    ,output logic        c_msb
`endif
);

    logic [K:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < K; i++) begin : g_cell
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign c_out = c[K];
`ifdef SEQ_ADDER_OVF_EN
    assign c_msb = c[K-1];
`endif

endmodule

// File: rtl/seq_adder_n.sv
// seq_adder_n: multi-cycle N-bit adder, one K-bit chunk per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow output ovf when SEQ_ADDER_OVF_EN is defined.
module seq_adder_n
    import seq_adder_n_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out
`ifdef SEQ_ADDER_OVF_EN
    ,output logic        ovf
`endif
);

    localparam int C    = N / K;
    localparam int IW   = idx_w(C);
    localparam int LAST = C - 1;
    localparam logic [N-1:0] CMASK = N'({K{1'b1}});

    if (N % K != 0) begin : g_bad_k
        $error("seq_adder_n: N must be a multiple of K");
    end

    state_e         state_q, state_d;
    logic [N-1:0]   x_q, x_d, y_q, y_d, s_q, s_d;
    logic           carry_q, carry_d, c_out_q, c_out_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [31:0]    sh;
    logic [K-1:0]   xa, ya, sum;
    logic           co, last;

    assign sh   = 32'(idx_q) * 32'(K);
    assign xa   = K'(x_q >> sh);
    assign ya   = K'(y_q >> sh);
    assign last = idx_q == IW'(LAST);

`ifdef SEQ_ADDER_OVF_EN
    logic c_msb, ovf_q, ovf_d;
    // On the final chunk the MSB cell is bit N-1, so c_msb is the carry into the sign bit.
    assign ovf_d = (state_q == ST_RUN && last) ? c_msb ^ co : ovf_q;
    always_ff @(posedge clock) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif

    full_adder_k #(.K(K)) u_fa (
        .x     (xa),
        .y     (ya),
        .c_in  (carry_q),
        .s     (sum),
        .c_out (co)
`ifdef SEQ_ADDER_OVF_EN
        ,.c_msb(c_msb)
`endif
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                x_d     = x;
                y_d     = y;
                carry_d = c_in;
                idx_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                s_d     = (s_q & ~(CMASK << sh)) | (N'(sum) << sh);
                carry_d = co;
                idx_d   = last ? '0 : idx_q + IW'(1);
                c_out_d = last ? co : c_out_q;
                state_d = last ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign s         = s_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_seq_adder_n.sv
// tb_seq_adder_n: directed and random checks of seq_adder_n for K in {1,2,4,8,16}, N=16.
// Index 2 (K=4) is the main device for the directed sequences.
module tb_seq_adder_n;

    logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0;
    logic [15:0] x = '0, y = '0;
    logic        in_ready_a[5], out_valid_a[5], c_out_a[5];
    logic [15:0] s_a[5];
`ifdef SEQ_ADDER_OVF_EN
    logic        ovf_a[5];
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;

    for (genvar j = 0; j < 5; j++) begin : g_dut
        seq_adder_n #(.N(16), .K(1 << j)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[j]),
            .x         (x),
            .y         (y),
            .c_in      (c_in),
            .out_valid (out_valid_a[j]),
            .out_ready (out_ready),
            .s         (s_a[j]),
            .c_out     (c_out_a[j])
`ifdef SEQ_ADDER_OVF_EN
            ,.ovf      (ovf_a[j])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid_a[2] && lat < 40);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         output logic [15:0] so, output logic co, output int lat);
        @(negedge clock);
        check("accept_ready", in_ready_a[2], 1);
        x = a; y = b; c_in = ci; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0; x = ~a; y = b ^ 16'h5a5a; c_in = ~ci;
        wait_valid(lat);
        so = s_a[2];
        co = c_out_a[2];
        release_result();
    endtask

    typedef struct {
        logic [15:0] x, y;
        logic        ci;
        logic [15:0] s;
        logic        co;
    } vec_t;

    initial begin
        vec_t        tv[8];
        logic [15:0] so;
        logic        co;
        int          lat;
        tv[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tv[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tv[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tv[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tv[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tv[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tv[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        tv[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_state", {in_ready_a[2], out_valid_a[2], c_out_a[2], s_a[2]}, {1'b1, 1'b0, 1'b0, 16'h0000});

        for (int i = 0; i < 8; i++) begin
            do_op(tv[i].x, tv[i].y, tv[i].ci, so, co, lat);
            check("vec_lat", lat, 4);
            check("vec_sum", {co, so}, {tv[i].co, tv[i].s});
            check("vec_idle_after", {in_ready_a[2], out_valid_a[2]}, 2'b10);
        end

        // in_valid held through RUN/DONE must be ignored until the DONE->IDLE edge has passed
        @(negedge clock);
        x = 16'h1111; y = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        x = 16'hFFFF; y = 16'h0001;
        check("busy_in_ready", in_ready_a[2], 0);
        wait_valid(lat);
        check("busy_lat", lat, 4);
        check("busy_sum", {c_out_a[2], s_a[2]}, {1'b0, 16'h3333});
        release_result();
        check("busy_back_idle", {in_ready_a[2], out_valid_a[2]}, 2'b10);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        check("busy_second_accepted", in_ready_a[2], 0);
        wait_valid(lat);
        check("busy2_lat", lat, 4);
        check("busy2_sum", {c_out_a[2], s_a[2]}, {1'b1, 16'h0000});
        release_result();

        // Backpressure: result held for 10 cycles while a new request is presented
        do begin @(negedge clock); end while (!in_ready_a[2]);
        x = 16'h1234; y = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", lat, 4);
        x = 16'h0F0F; y = 16'h0F0F; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_hold", {out_valid_a[2], in_ready_a[2], c_out_a[2], s_a[2]}, {1'b1, 1'b0, 1'b0, 16'h5555});
        end
        in_valid = 1'b0;
        release_result();

        // Reset asserted on the 2nd RUN edge aborts the operation
        x = 16'hFFFF; y = 16'h0001; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_state", {in_ready_a[2], out_valid_a[2], c_out_a[2], s_a[2]}, {1'b1, 1'b0, 1'b0, 16'h0000});
        repeat (5) @(negedge clock);
        check("abort_no_result", out_valid_a[2], 0);

`ifdef SEQ_ADDER_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, so, co, lat);
        check("ovf_pos", {ovf_a[2], co, so}, {1'b1, 1'b0, 16'h8000});
        do_op(16'hFFFF, 16'h0001, 1'b0, so, co, lat);
        check("ovf_neg", {ovf_a[2], co, so}, {1'b0, 1'b1, 16'h0000});
`endif

        // Parameter sweep: all five widths run the same random operation side by side
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            logic [15:0] a, b;
            logic        ci;
            logic [16:0] exp;
            int          lat_a[5];
            int          cyc;
            bit          all;
            a = 16'($urandom);
            b = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {16'b0, ci};
            @(negedge clock);
            check("sweep_ready", {in_ready_a[0], in_ready_a[1], in_ready_a[2], in_ready_a[3], in_ready_a[4]}, 5'h1F);
            x = a; y = b; c_in = ci; in_valid = 1'b1;
            @(posedge clock);
            @(negedge clock);
            in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom);
            lat_a = '{default: 0};
            cyc = 0;
            all = 1'b0;
            while (!all && cyc < 20) begin
                @(negedge clock);
                cyc++;
                all = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    if (out_valid_a[j] && lat_a[j] == 0) lat_a[j] = cyc;
                    if (lat_a[j] == 0) all = 1'b0;
                end
            end
            for (int j = 0; j < 5; j++) begin
                check("sweep_lat", lat_a[j], 16 >> j);
                check("sweep_sum", {c_out_a[j], s_a[j]}, exp);
            end
            release_result();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
